// File: rtl/mor1kx_bpred_pht_ctrl_pkg.sv
// Shared definitions for the gshare pattern history table controller:
// 2-bit counter encodings, the sweep fill value and the saturating update rule.
package mor1kx_bpred_pht_ctrl_pkg;

  localparam logic [1:0] PHT_SNT = 2'b00;
  localparam logic [1:0] PHT_WNT = 2'b01;
  localparam logic [1:0] PHT_WT  = 2'b10;
  localparam logic [1:0] PHT_ST  = 2'b11;

  localparam logic [1:0] PHT_INIT_VALUE = PHT_WT;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_RD = 2'd2,
    ST_UPD_WR = 2'd3
  } pht_state_e;

  // Taken moves the counter towards ST, not-taken towards SNT; both ends stick.
  function automatic logic [1:0] pht_sat_update(input logic [1:0] cnt,
                                                input logic       taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != PHT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != PHT_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mor1kx_bpred_upd_fifo.sv
// Small synchronous FIFO holding pending PHT updates as {idx, taken}.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mor1kx_bpred_upd_fifo #(
  parameter int DATA_WIDTH = 11,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mor1kx_bpred_pht_ctrl.sv
// Sequences a single-port PHT RAM between decode lookups, buffered resolve-stage
// read-modify-write updates and the post-reset/flush initialisation sweep.
module mor1kx_bpred_pht_ctrl
  import mor1kx_bpred_pht_ctrl_pkg::*;
#(
  parameter int PHT_IDX_WIDTH  = 10,
  parameter int UPD_FIFO_DEPTH = 4,
  parameter int STARVE_MAX     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     lk_req_i,
  input  logic [PHT_IDX_WIDTH-1:0] lk_idx_i,
  output logic                     lk_gnt_o,
  output logic                     lk_valid_o,
  output logic                     lk_taken_o,
  input  logic                     upd_valid_i,
  input  logic [PHT_IDX_WIDTH-1:0] upd_idx_i,
  input  logic                     upd_taken_i,
  output logic                     upd_ready_o,
  output logic                     busy_o,
  output logic                     ram_en_o,
  output logic                     ram_we_o,
  output logic [PHT_IDX_WIDTH-1:0] ram_addr_o,
  output logic [1:0]               ram_wdata_o,
  input  logic [1:0]               ram_rdata_i
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]            STARVE_LIMIT = SW'(STARVE_MAX);
  localparam logic [SW-1:0]            STARVE_ONE   = SW'(1);
  localparam logic [PHT_IDX_WIDTH-1:0] SWEEP_LAST   = {PHT_IDX_WIDTH{1'b1}};
  localparam logic [PHT_IDX_WIDTH-1:0] SWEEP_ONE    = PHT_IDX_WIDTH'(1);

  pht_state_e               state_q, state_d;
  logic [PHT_IDX_WIDTH-1:0] sweep_q, sweep_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic [1:0]               cnt_q;
  logic                     lk_valid_q;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [PHT_IDX_WIDTH:0]   fifo_head;
  logic [PHT_IDX_WIDTH-1:0] head_idx;
  logic                     head_taken;

  assign head_idx   = fifo_head[PHT_IDX_WIDTH:1];
  assign head_taken = fifo_head[0];

  // Update handshake: an update is taken exactly in a cycle where upd_valid_i
  // and upd_ready_o are both high; the producer must hold it otherwise.
  // A flush in the same cycle wins, so that update is dropped with the rest.
  assign busy_o      = (state_q == ST_INIT);
  assign upd_ready_o = !busy_o && !fifo_full;
  assign fifo_push   = upd_valid_i && upd_ready_o && !flush_i;

  mor1kx_bpred_upd_fifo #(
    .DATA_WIDTH (PHT_IDX_WIDTH + 1),
    .DEPTH      (UPD_FIFO_DEPTH)
  ) u_upd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush_i),
    .push      (fifo_push),
    .push_data ({upd_idx_i, upd_taken_i}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      starve_q   <= '0;
      cnt_q      <= '0;
      lk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      starve_q   <= starve_d;
      lk_valid_q <= lk_gnt_o;
      if (state_q == ST_UPD_RD) cnt_q <= ram_rdata_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    starve_d    = starve_q;
    lk_gnt_o    = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    fifo_pop    = 1'b0;

    if (flush_i) begin
      // Abandons any read-modify-write in progress; the sweep rewrites it all.
      state_d  = ST_INIT;
      sweep_d  = '0;
      starve_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Outputs stay quiet while reset is held even though the state is INIT.
          if (rst_n) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = sweep_q;
            ram_wdata_o = PHT_INIT_VALUE;
          end
          sweep_d = sweep_q + SWEEP_ONE;
          if (sweep_q == SWEEP_LAST) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (!fifo_empty && (starve_q == STARVE_LIMIT || !lk_req_i)) begin
            ram_en_o   = 1'b1;
            ram_addr_o = head_idx;
            starve_d   = '0;
            state_d    = ST_UPD_RD;
          end else if (lk_req_i) begin
            lk_gnt_o   = 1'b1;
            ram_en_o   = 1'b1;
            ram_addr_o = lk_idx_i;
            if (fifo_empty)                  starve_d = '0;
            else if (starve_q != STARVE_LIMIT) starve_d = starve_q + STARVE_ONE;
          end else begin
            starve_d = '0;
          end
        end
        ST_UPD_RD: begin
          state_d = ST_UPD_WR;
        end
        ST_UPD_WR: begin
          ram_en_o    = 1'b1;
          ram_we_o    = 1'b1;
          ram_addr_o  = head_idx;
          ram_wdata_o = pht_sat_update(cnt_q, head_taken);
          fifo_pop    = 1'b1;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign lk_valid_o = lk_valid_q;
  assign lk_taken_o = lk_valid_q & ram_rdata_i[1];

endmodule

// File: tb/tb_mor1kx_bpred_pht_ctrl.sv
// Bench for the PHT controller: a behavioural RAM plus a queue-based reference
// model of arbitration, counter updates and lookup results, driven randomly.
module tb_mor1kx_bpred_pht_ctrl;

  localparam int IW     = 4;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;
  localparam int NENT   = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i;
  logic          lk_req_i;
  logic [IW-1:0] lk_idx_i;
  logic          lk_gnt_o;
  logic          lk_valid_o;
  logic          lk_taken_o;
  logic          upd_valid_i;
  logic [IW-1:0] upd_idx_i;
  logic          upd_taken_i;
  logic          upd_ready_o;
  logic          busy_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [IW-1:0] ram_addr_o;
  logic [1:0]    ram_wdata_o;
  logic [1:0]    ram_rdata_i;

  always #5 clk = ~clk;

  mor1kx_bpred_pht_ctrl #(
    .PHT_IDX_WIDTH  (IW),
    .UPD_FIFO_DEPTH (DEPTH),
    .STARVE_MAX     (STARVE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .lk_req_i    (lk_req_i),
    .lk_idx_i    (lk_idx_i),
    .lk_gnt_o    (lk_gnt_o),
    .lk_valid_o  (lk_valid_o),
    .lk_taken_o  (lk_taken_o),
    .upd_valid_i (upd_valid_i),
    .upd_idx_i   (upd_idx_i),
    .upd_taken_i (upd_taken_i),
    .upd_ready_o (upd_ready_o),
    .busy_o      (busy_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  // Single-port synchronous RAM; read data holds until the next read.
  logic [1:0] mem [NENT];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata_i     <= mem[ram_addr_o];
    end
  end

  // Reference model state
  logic [1:0]  ref_pht [NENT];
  logic [IW:0] upd_q[$];
  logic [1:0]  exp_q[$];
  int          m_init_left;
  int          m_sweep_pos;
  int          m_stage;
  int          m_starve;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] next_cnt(input logic [1:0] c, input logic t);
    int v;
    v = int'(c);
    if (t) v = (v >= 3) ? 3 : v + 1;
    else   v = (v <= 0) ? 0 : v - 1;
    return 2'(v);
  endfunction

  task automatic model_reset();
    m_init_left = NENT;
    m_sweep_pos = 0;
    m_stage     = 0;
    m_starve    = 0;
    upd_q.delete();
    exp_q.delete();
  endtask

  // Evaluated between edges: checks outputs for the coming edge, then advances.
  task automatic model_step();
    logic [1:0]    e_rd;
    logic [1:0]    e_wd;
    logic [IW-1:0] h_idx;
    logic          h_t;
    bit            e_busy, e_ready, e_gnt, e_en, e_we, push;
    int            e_addr;

    check("lk_valid", lk_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e_rd = exp_q.pop_front();
      check("lk_taken", lk_taken_o, e_rd[1]);
    end

    e_busy  = (m_init_left > 0);
    e_ready = !e_busy && (upd_q.size() < DEPTH);
    e_gnt = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 2'b00;
    push  = upd_valid_i && e_ready && !flush_i;

    if (flush_i) begin
      m_init_left = NENT;
      m_sweep_pos = 0;
      m_stage     = 0;
      m_starve    = 0;
      upd_q.delete();
    end else if (e_busy) begin
      e_en = 1; e_we = 1; e_addr = m_sweep_pos; e_wd = 2'b10;
      ref_pht[m_sweep_pos] = 2'b10;
      m_sweep_pos++;
      m_init_left--;
    end else if (m_stage == 1) begin
      m_stage = 2;
    end else if (m_stage == 2) begin
      h_idx = upd_q[0][IW:1];
      h_t   = upd_q[0][0];
      e_wd  = next_cnt(ref_pht[h_idx], h_t);
      e_en = 1; e_we = 1; e_addr = int'(h_idx);
      ref_pht[h_idx] = e_wd;
      void'(upd_q.pop_front());
      m_stage = 0;
    end else if (upd_q.size() != 0 && (m_starve == STARVE || !lk_req_i)) begin
      e_en = 1; e_addr = int'(upd_q[0][IW:1]);
      m_stage  = 1;
      m_starve = 0;
    end else if (lk_req_i) begin
      e_gnt = 1; e_en = 1; e_addr = int'(lk_idx_i);
      exp_q.push_back(ref_pht[lk_idx_i]);
      if (upd_q.size() == 0)      m_starve = 0;
      else if (m_starve < STARVE) m_starve++;
    end else begin
      m_starve = 0;
    end
    if (push) upd_q.push_back({upd_idx_i, upd_taken_i});

    check("busy", busy_o, e_busy);
    check("upd_ready", upd_ready_o, e_ready);
    check("lk_gnt", lk_gnt_o, e_gnt);
    check("ram_en", ram_en_o, e_en);
    check("ram_we", ram_we_o, e_we);
    if (e_en) check("ram_addr", ram_addr_o, e_addr);
    if (e_we) check("ram_wdata", ram_wdata_o, e_wd);
  endtask

  // Inputs are set just after a rising edge; tick checks and crosses the next edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy_o, 1);
    check({tag, "_gnt"}, lk_gnt_o, 0);
    check({tag, "_valid"}, lk_valid_o, 0);
    check({tag, "_taken"}, lk_taken_o, 0);
    check({tag, "_ready"}, upd_ready_o, 0);
    check({tag, "_en"}, ram_en_o, 0);
    check({tag, "_we"}, ram_we_o, 0);
  endtask

  task automatic push_upd(input int idx, input bit t);
    upd_valid_i = 1'b1;
    upd_idx_i   = IW'(idx);
    upd_taken_i = t;
    tick();
    upd_valid_i = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      flush_i     = ($urandom_range(0, 299) == 0);
      lk_req_i    = ($urandom_range(0, 9) < 7);
      lk_idx_i    = IW'($urandom_range(0, NENT - 1));
      upd_valid_i = ($urandom_range(0, 9) < 3);
      upd_idx_i   = IW'($urandom_range(0, NENT - 1));
      upd_taken_i = 1'($urandom_range(0, 1));
      tick();
    end
    flush_i = 1'b0; lk_req_i = 1'b0; upd_valid_i = 1'b0;
  endtask

  initial begin
    flush_i = 0; lk_req_i = 0; lk_idx_i = '0;
    upd_valid_i = 0; upd_idx_i = '0; upd_taken_i = 0;
    ram_rdata_i = 2'b00;
    for (int i = 0; i < NENT; i++) begin
      mem[i]     = 2'($urandom_range(0, 3));
      ref_pht[i] = 2'b00;
    end
    model_reset();

    #3;
    check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Init sweep with lookups requested the whole time
    lk_req_i = 1'b1;
    for (int i = 0; i < NENT; i++) begin
      lk_idx_i = IW'($urandom_range(0, NENT - 1));
      tick();
    end

    // First lookup after init
    lk_idx_i = IW'(5);
    tick();
    lk_req_i = 1'b0;
    tick();
    tick();

    // Saturating up then down on idx 3
    for (int i = 0; i < 3; i++) begin
      push_upd(3, 1'b1);
      repeat (3) tick();
    end
    for (int i = 0; i < 4; i++) begin
      push_upd(3, 1'b0);
      repeat (3) tick();
    end
    lk_req_i = 1'b1; lk_idx_i = IW'(3);
    tick();
    lk_req_i = 1'b0;
    tick();

    // Starvation limit with lookups held
    lk_req_i = 1'b1;
    upd_valid_i = 1'b1; upd_idx_i = IW'(9); upd_taken_i = 1'b0;
    tick();
    upd_valid_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      lk_idx_i = IW'($urandom_range(0, NENT - 1));
      tick();
    end

    // Overfill the FIFO while lookups hold the port
    for (int i = 0; i < 5; i++) begin
      upd_valid_i = 1'b1;
      upd_idx_i   = IW'($urandom_range(0, NENT - 1));
      upd_taken_i = 1'($urandom_range(0, 1));
      lk_idx_i    = IW'($urandom_range(0, NENT - 1));
      tick();
    end
    upd_valid_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      lk_idx_i = IW'($urandom_range(0, NENT - 1));
      tick();
    end
    lk_req_i = 1'b0;
    repeat (6) tick();

    // Flush while an update read is in flight with a second entry queued
    push_upd(7, 1'b1);
    push_upd(11, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (NENT + 4) tick();

    random_phase(1500);

    // Asynchronous reset in the middle of traffic
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("held_reset");
    rst_n = 1'b1;

    random_phase(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
